// File: rtl/seq_det_pkg.sv
// Shared constants for the 1011 serial sequence detector: state encodings and pattern description.
package seq_det_pkg;

    localparam logic [1:0] S0   = 2'b00;
    localparam logic [1:0] S1   = 2'b01;
    localparam logic [1:0] S10  = 2'b10;
    localparam logic [1:0] S101 = 2'b11;

    localparam logic [3:0]  PATTERN     = 4'b1011;
    localparam int unsigned PATTERN_LEN = 4;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment) and a sticky saturation flag.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + W'(1);
        end
        // Count never wraps, so reaching all-ones keeps the flag set until a clear.
        sat_d = (count_d == MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule : sat_counter

// File: rtl/seq_detector_1011.sv
// Serial 1011 detector: four-state FSM advanced by din_valid, registered match pulse, saturating match counter.
module seq_detector_1011
    import seq_det_pkg::*;
#(
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               clear_count,
    output logic               detected,
    output logic [1:0]         state_o,
    output logic [COUNT_W-1:0] match_count,
    output logic               count_sat
);

    logic [1:0] state_q, state_d;
    logic       det_q, det_d;
    logic       match_c;

    // Next-state and match decode; state holds whenever din is not qualified.
    always_comb begin
        state_d = state_q;
        match_c = 1'b0;
        if (din_valid) begin
            case (state_q)
                S0:      state_d = din ? S1 : S0;
                S1:      state_d = din ? S1 : S10;
                S10:     state_d = din ? S101 : S0;
                default: begin
                    if (din) begin
                        match_c = 1'b1;
                        state_d = OVERLAP ? S1 : S0;
                    end else begin
                        state_d = S10;
                    end
                end
            endcase
        end
        det_d = match_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
        end
    end

    sat_counter #(
        .W (COUNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_c),
        .clr   (clear_count),
        .count (match_count),
        .sat   (count_sat)
    );

    assign detected = det_q;
    assign state_o  = state_q;

endmodule : seq_detector_1011
